// File: rtl/rom_access_seq.sv
// ROM/SRAM access sequencer: arbitrates SNES and MCU accesses and
// generates timed strobes on the 16-bit external memory with byte lanes.
module rom_access_seq #(
  parameter int RD_CYCLES = 4,
  parameter int WR_CYCLES = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        snes_req_i,
  input  logic        snes_we_i,
  input  logic        snes_wr_en_i,
  input  logic [23:0] snes_addr_i,
  input  logic [7:0]  snes_din_i,
  output logic [7:0]  snes_dout_o,
  output logic        snes_valid_o,
  input  logic        mcu_rrq_i,
  input  logic        mcu_wrq_i,
  input  logic [23:0] mcu_addr_i,
  input  logic [7:0]  mcu_din_i,
  output logic [7:0]  mcu_dout_o,
  output logic        mcu_rdy_o,
  output logic [22:0] rom_a_o,
  output logic [15:0] rom_dq_o,
  input  logic [15:0] rom_dq_i,
  output logic        rom_dq_oe_o,
  output logic        rom_ce_n_o,
  output logic        rom_oe_n_o,
  output logic        rom_we_n_o,
  output logic        rom_bhe_n_o,
  output logic        rom_ble_n_o
);

  localparam int CW = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNES_RD,
    S_SNES_WR,
    S_MCU_RD,
    S_MCU_WR,
    S_RECOVER
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          lane_q;

  logic          snes_pend_q;
  logic          snes_we_q;
  logic          snes_en_q;
  logic [23:0]   snes_addr_q;
  logic [7:0]    snes_din_q;

  logic          mcu_pend_q;
  logic          mcu_we_q;
  logic [23:0]   mcu_addr_q;
  logic [7:0]    mcu_din_q;

  logic          ce_n_q;
  logic          oe_n_q;
  logic          we_n_q;
  logic          bhe_n_q;
  logic          ble_n_q;
  logic          dq_oe_q;
  logic [22:0]   rom_a_q;
  logic [15:0]   dq_o_q;
  logic [7:0]    snes_dout_q;
  logic          snes_valid_q;
  logic [7:0]    mcu_dout_q;
  logic          mcu_rdy_q;

  // Same-clock requests take precedence over older pending copies
  logic        s_any;
  logic        s_we;
  logic        s_en;
  logic [23:0] s_addr;
  logic [7:0]  s_din;
  logic        m_acc;
  logic        m_any;
  logic        m_we;
  logic [23:0] m_addr;
  logic [7:0]  m_din;
  logic [7:0]  rd_byte;
  logic        rd_last;
  logic        wr_last;
  logic        wr_hold;

  assign s_any  = snes_req_i | snes_pend_q;
  assign s_we   = snes_req_i ? snes_we_i    : snes_we_q;
  assign s_en   = snes_req_i ? snes_wr_en_i : snes_en_q;
  assign s_addr = snes_req_i ? snes_addr_i  : snes_addr_q;
  assign s_din  = snes_req_i ? snes_din_i   : snes_din_q;

  assign m_acc  = (mcu_rrq_i | mcu_wrq_i) & mcu_rdy_q;
  assign m_any  = m_acc | mcu_pend_q;
  assign m_we   = m_acc ? ~mcu_rrq_i : mcu_we_q;
  assign m_addr = m_acc ? mcu_addr_i : mcu_addr_q;
  assign m_din  = m_acc ? mcu_din_i  : mcu_din_q;

  assign rd_byte = lane_q ? rom_dq_i[15:8] : rom_dq_i[7:0];
  assign rd_last = cnt_q == CW'(RD_CYCLES - 1);
  assign wr_last = cnt_q == CW'(WR_CYCLES - 1);
  assign wr_hold = cnt_q == CW'(WR_CYCLES);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      lane_q       <= 1'b0;
      snes_pend_q  <= 1'b0;
      snes_we_q    <= 1'b0;
      snes_en_q    <= 1'b0;
      snes_addr_q  <= '0;
      snes_din_q   <= '0;
      mcu_pend_q   <= 1'b0;
      mcu_we_q     <= 1'b0;
      mcu_addr_q   <= '0;
      mcu_din_q    <= '0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      bhe_n_q      <= 1'b1;
      ble_n_q      <= 1'b1;
      dq_oe_q      <= 1'b0;
      rom_a_q      <= '0;
      dq_o_q       <= '0;
      snes_dout_q  <= '0;
      snes_valid_q <= 1'b0;
      mcu_dout_q   <= '0;
      mcu_rdy_q    <= 1'b1;
    end else begin
      snes_valid_q <= 1'b0;

      if (snes_req_i) begin
        snes_pend_q <= 1'b1;
        snes_we_q   <= snes_we_i;
        snes_en_q   <= snes_wr_en_i;
        snes_addr_q <= snes_addr_i;
        snes_din_q  <= snes_din_i;
      end

      if (m_acc) begin
        mcu_pend_q <= 1'b1;
        mcu_rdy_q  <= 1'b0;
        mcu_we_q   <= ~mcu_rrq_i;
        mcu_addr_q <= mcu_addr_i;
        mcu_din_q  <= mcu_din_i;
      end

      unique case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (s_any) begin
            snes_pend_q <= 1'b0;
            rom_a_q     <= s_addr[23:1];
            lane_q      <= s_addr[0];
            dq_o_q      <= {s_din, s_din};
            if (s_we && !s_en) begin
              // Write-protected target: acknowledge without touching pins
              snes_valid_q <= 1'b1;
              state_q      <= S_RECOVER;
            end else begin
              ce_n_q  <= 1'b0;
              bhe_n_q <= ~s_addr[0];
              ble_n_q <= s_addr[0];
              if (s_we) begin
                we_n_q  <= 1'b0;
                dq_oe_q <= 1'b1;
                state_q <= S_SNES_WR;
              end else begin
                oe_n_q  <= 1'b0;
                state_q <= S_SNES_RD;
              end
            end
          end else if (m_any) begin
            mcu_pend_q <= 1'b0;
            mcu_rdy_q  <= 1'b0;
            rom_a_q    <= m_addr[23:1];
            lane_q     <= m_addr[0];
            dq_o_q     <= {m_din, m_din};
            ce_n_q     <= 1'b0;
            bhe_n_q    <= ~m_addr[0];
            ble_n_q    <= m_addr[0];
            if (m_we) begin
              we_n_q  <= 1'b0;
              dq_oe_q <= 1'b1;
              state_q <= S_MCU_WR;
            end else begin
              oe_n_q  <= 1'b0;
              state_q <= S_MCU_RD;
            end
          end
        end

        S_SNES_RD, S_MCU_RD: begin
          cnt_q <= cnt_q + 1'b1;
          if (rd_last) begin
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            bhe_n_q <= 1'b1;
            ble_n_q <= 1'b1;
            state_q <= S_RECOVER;
            if (state_q == S_SNES_RD) begin
              snes_dout_q  <= rd_byte;
              snes_valid_q <= 1'b1;
            end else begin
              mcu_dout_q <= rd_byte;
              mcu_rdy_q  <= 1'b1;
            end
          end
        end

        S_SNES_WR, S_MCU_WR: begin
          cnt_q <= cnt_q + 1'b1;
          // Data stays driven one clock past WE_N release for hold time
          if (wr_last) begin
            ce_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            bhe_n_q <= 1'b1;
            ble_n_q <= 1'b1;
            if (state_q == S_SNES_WR) begin
              snes_valid_q <= 1'b1;
            end else begin
              mcu_rdy_q <= 1'b1;
            end
          end
          if (wr_hold) begin
            dq_oe_q <= 1'b0;
            state_q <= S_RECOVER;
          end
        end

        S_RECOVER: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign snes_dout_o  = snes_dout_q;
  assign snes_valid_o = snes_valid_q;
  assign mcu_dout_o   = mcu_dout_q;
  assign mcu_rdy_o    = mcu_rdy_q;
  assign rom_a_o      = rom_a_q;
  assign rom_dq_o     = dq_o_q;
  assign rom_dq_oe_o  = dq_oe_q;
  assign rom_ce_n_o   = ce_n_q;
  assign rom_oe_n_o   = oe_n_q;
  assign rom_we_n_o   = we_n_q;
  assign rom_bhe_n_o  = bhe_n_q;
  assign rom_ble_n_o  = ble_n_q;

endmodule

// File: tb/tb_rom_access_seq.sv
// Bench for rom_access_seq: pin-level SRAM model plus a byte-addressed
// reference memory updated from access semantics.
module tb_rom_access_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        snes_req = 0, snes_we = 0, snes_wr_en = 0;
  logic [23:0] snes_addr = '0;
  logic [7:0]  snes_din = '0;
  logic [7:0]  snes_dout;
  logic        snes_valid;
  logic        mcu_rrq = 0, mcu_wrq = 0;
  logic [23:0] mcu_addr = '0;
  logic [7:0]  mcu_din = '0;
  logic [7:0]  mcu_dout;
  logic        mcu_rdy;
  logic [22:0] rom_a;
  logic [15:0] dq_o;
  logic [15:0] rom_dq_i = '0;
  logic        dq_oe, ce_n, oe_n, we_n, bhe_n, ble_n;

  int checks = 0;
  int errors = 0;

  rom_access_seq #(.RD_CYCLES(4), .WR_CYCLES(5)) dut (
    .clk_i(clk), .rst_i(rst),
    .snes_req_i(snes_req), .snes_we_i(snes_we),
    .snes_wr_en_i(snes_wr_en), .snes_addr_i(snes_addr),
    .snes_din_i(snes_din), .snes_dout_o(snes_dout),
    .snes_valid_o(snes_valid),
    .mcu_rrq_i(mcu_rrq), .mcu_wrq_i(mcu_wrq),
    .mcu_addr_i(mcu_addr), .mcu_din_i(mcu_din),
    .mcu_dout_o(mcu_dout), .mcu_rdy_o(mcu_rdy),
    .rom_a_o(rom_a), .rom_dq_o(dq_o), .rom_dq_i(rom_dq_i),
    .rom_dq_oe_o(dq_oe), .rom_ce_n_o(ce_n),
    .rom_oe_n_o(oe_n), .rom_we_n_o(we_n),
    .rom_bhe_n_o(bhe_n), .rom_ble_n_o(ble_n)
  );

  always #5 clk = ~clk;

  logic [15:0] ram [int];
  logic [7:0]  refm [int];

  function automatic logic [15:0] init_word(int wa);
    return 16'(wa * 40503) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] ram_word(int wa);
    if (ram.exists(wa)) return ram[wa];
    return init_word(wa);
  endfunction

  function automatic logic [7:0] ref_get(logic [23:0] a);
    logic [15:0] w;
    if (refm.exists(int'(a))) return refm[int'(a)];
    w = init_word(int'(a[23:1]));
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  // Pin-level SRAM: reads drive the bus, writes commit on WE_N rising
  int          we_cnt = 0, ov_viol = 0, a_viol = 0, pin_viol = 0;
  logic        p_we = 1, p_ble = 1, p_bhe = 1, in_acc = 0;
  logic [15:0] p_dq = '0;
  logic [22:0] a_hold = '0;
  int          pa = 0;

  always @(negedge clk) begin
    logic [15:0] w;
    rom_dq_i <= (!ce_n && !oe_n) ? ram_word(int'(rom_a)) : 16'h0000;
    if (rst) begin
      p_we = 1'b1;
      in_acc = 1'b0;
    end else begin
      if (dq_oe && !oe_n) ov_viol++;
      if (!we_n && (!dq_oe || ce_n)) pin_viol++;
      if (!ce_n) begin
        if (!in_acc) begin
          in_acc = 1'b1;
          a_hold = rom_a;
        end else if (rom_a !== a_hold) a_viol++;
      end else in_acc = 1'b0;
      if (!p_we && we_n) begin
        w = ram_word(pa);
        if (!p_ble) w[7:0] = p_dq[7:0];
        if (!p_bhe) w[15:8] = p_dq[15:8];
        ram[pa] = w;
        we_cnt++;
      end
      p_we = we_n;
      p_ble = ble_n;
      p_bhe = bhe_n;
      p_dq = dq_o;
      pa = int'(rom_a);
    end
  end

  task automatic mcu_read(input logic [23:0] a, output logic [7:0] d,
                          output bit to);
    @(negedge clk);
    mcu_rrq = 1;
    mcu_addr = a;
    @(negedge clk);
    mcu_rrq = 0;
    to = 1;
    for (int k = 1; k < 60; k++) begin
      if (mcu_rdy) begin
        to = 0;
        break;
      end
      @(negedge clk);
    end
    d = mcu_dout;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ce_n, oe_n, we_n, bhe_n, ble_n, dq_oe} !== 6'b111110) begin
      errors++;
      $display("FAIL reset_pins got %b want 111110",
               {ce_n, oe_n, we_n, bhe_n, ble_n, dq_oe});
    end
    checks++;
    if ({rom_a, snes_dout, mcu_dout, snes_valid} !== '0) begin
      errors++;
      $display("FAIL reset_zero a=%h sd=%h md=%h v=%b want 0",
               rom_a, snes_dout, mcu_dout, snes_valid);
    end
    checks++;
    if (mcu_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy got %b want 1", mcu_rdy);
    end
    rst = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_write;
    logic [7:0] exp, d;
    bit to;
    int we0;
    exp = ref_get(24'h50);
    we0 = we_cnt;
    @(negedge clk);
    mcu_wrq = 1;
    mcu_addr = 24'h50;
    mcu_din = 8'hEE;
    @(negedge clk);
    mcu_wrq = 0;
    checks++;
    if (we_n !== 1'b0) begin
      errors++;
      $display("FAIL rstw_start we_n got %b want 0", we_n);
    end
    repeat (2) @(negedge clk);
    #2 rst = 1;
    #1;
    checks++;
    if ({ce_n, oe_n, we_n, bhe_n, ble_n, dq_oe, mcu_rdy} !== 7'b1111101) begin
      errors++;
      $display("FAIL rstw_async got %b want 1111101",
               {ce_n, oe_n, we_n, bhe_n, ble_n, dq_oe, mcu_rdy});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({ce_n, we_n, dq_oe, mcu_rdy} !== 4'b1101) begin
      errors++;
      $display("FAIL rstw_edge got %b want 1101",
               {ce_n, we_n, dq_oe, mcu_rdy});
    end
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    checks++;
    if (we_cnt !== we0) begin
      errors++;
      $display("FAIL rstw_commits got %0d want %0d", we_cnt, we0);
    end
    mcu_read(24'h50, d, to);
    checks++;
    if (to || d !== exp) begin
      errors++;
      $display("FAIL rstw_ram got %h (to=%0d) want %h", d, to, exp);
    end
  endtask

  task automatic test_snes_read;
    logic [6:0] pv, ev;
    ram[0] = 16'hA55A;
    refm[0] = 8'h5A;
    refm[1] = 8'hA5;
    @(negedge clk);
    snes_req = 1;
    snes_we = 0;
    snes_addr = 24'h000001;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) snes_req = 0;
      pv = {ce_n, oe_n, we_n, bhe_n, ble_n, dq_oe, snes_valid};
      ev = (k <= 4) ? 7'b0010100 : (k == 5) ? 7'b1111101 : 7'b1111100;
      checks++;
      if (pv !== ev) begin
        errors++;
        $display("FAIL rd_pins clk%0d got %b want %b", k, pv, ev);
      end
      if (k == 5) begin
        checks++;
        if (snes_dout !== 8'hA5) begin
          errors++;
          $display("FAIL rd_data got %h want a5", snes_dout);
        end
      end
    end
  endtask

  task automatic test_snes_write;
    logic [6:0] pv, ev;
    logic [7:0] d;
    bit to;
    @(negedge clk);
    snes_req = 1;
    snes_we = 1;
    snes_wr_en = 1;
    snes_addr = 24'hE00000;
    snes_din = 8'h3C;
    refm[int'(24'hE00000)] = 8'h3C;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) snes_req = 0;
      pv = {ce_n, oe_n, we_n, bhe_n, ble_n, dq_oe, snes_valid};
      ev = (k <= 5) ? 7'b0101010 : (k == 6) ? 7'b1111111 : 7'b1111100;
      checks++;
      if (pv !== ev) begin
        errors++;
        $display("FAIL wr_pins clk%0d got %b want %b", k, pv, ev);
      end
      if (k <= 6) begin
        checks++;
        if (dq_o !== 16'h3C3C || rom_a !== 23'h700000) begin
          errors++;
          $display("FAIL wr_bus clk%0d dq=%h a=%h want 3c3c 700000",
                   k, dq_o, rom_a);
        end
      end
    end
    snes_we = 0;
    mcu_read(24'hE00000, d, to);
    checks++;
    if (to || d !== 8'h3C) begin
      errors++;
      $display("FAIL wr_readback got %h (to=%0d) want 3c", d, to);
    end
  endtask

  task automatic test_arbitration;
    logic [7:0] es, em;
    es = ref_get(24'h10);
    em = ref_get(24'h21);
    @(negedge clk);
    snes_req = 1;
    snes_we = 0;
    snes_addr = 24'h10;
    mcu_rrq = 1;
    mcu_addr = 24'h21;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        snes_req = 0;
        mcu_rrq = 0;
      end
      checks++;
      if (mcu_rdy !== (k >= 11)) begin
        errors++;
        $display("FAIL arb_rdy clk%0d got %b want %b", k, mcu_rdy, k >= 11);
      end
      if (k == 5) begin
        checks++;
        if (snes_valid !== 1'b1 || snes_dout !== es) begin
          errors++;
          $display("FAIL arb_snes v=%b d=%h want 1 %h", snes_valid,
                   snes_dout, es);
        end
      end
      if (k == 11) begin
        checks++;
        if (mcu_dout !== em) begin
          errors++;
          $display("FAIL arb_mcu got %h want %h", mcu_dout, em);
        end
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wr_disabled;
    logic [7:0] e30, e32, d;
    logic [3:0] pv, ev;
    bit to;
    int we0;
    e30 = ref_get(24'h30);
    e32 = ref_get(24'h32);
    we0 = we_cnt;
    @(negedge clk);
    snes_req = 1;
    snes_we = 1;
    snes_wr_en = 0;
    snes_addr = 24'h30;
    snes_din = 8'h77;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      snes_req = 0;
      pv = {we_n, ce_n, dq_oe, snes_valid};
      ev = (k == 1) ? 4'b1101 : 4'b1100;
      checks++;
      if (pv !== ev) begin
        errors++;
        $display("FAIL wrdis_pins clk%0d got %b want %b", k, pv, ev);
      end
    end
    snes_we = 0;
    mcu_wrq = 1;
    mcu_addr = 24'h31;
    mcu_din = 8'h11;
    refm[int'(24'h31)] = 8'h11;
    to = 1;
    for (int k = 1; k < 60; k++) begin
      @(negedge clk);
      mcu_wrq = (k == 2);
      if (k == 2) begin
        mcu_addr = 24'h32;
        mcu_din = 8'h99;
      end
      if (k > 2 && mcu_rdy) begin
        to = 0;
        break;
      end
    end
    mcu_wrq = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (to || we_cnt !== we0 + 1) begin
      errors++;
      $display("FAIL wrdis_commits got %0d (to=%0d) want %0d",
               we_cnt, to, we0 + 1);
    end
    mcu_read(24'h32, d, to);
    checks++;
    if (to || d !== e32) begin
      errors++;
      $display("FAIL ignored_wrq got %h want %h", d, e32);
    end
    mcu_read(24'h30, d, to);
    checks++;
    if (to || d !== e30) begin
      errors++;
      $display("FAIL wrdis_lo got %h want %h", d, e30);
    end
    mcu_read(24'h31, d, to);
    checks++;
    if (to || d !== 8'h11) begin
      errors++;
      $display("FAIL mcu_wr_hi got %h want 11", d);
    end
  endtask

  task automatic test_rrq_wrq;
    logic [7:0] e, d;
    bit to;
    int we0;
    e = ref_get(24'h40);
    we0 = we_cnt;
    @(negedge clk);
    mcu_rrq = 1;
    mcu_wrq = 1;
    mcu_addr = 24'h40;
    mcu_din = 8'h55;
    @(negedge clk);
    mcu_rrq = 0;
    mcu_wrq = 0;
    to = 1;
    for (int k = 1; k < 60; k++) begin
      if (mcu_rdy) begin
        to = 0;
        break;
      end
      @(negedge clk);
    end
    d = mcu_dout;
    repeat (3) @(negedge clk);
    checks++;
    if (to || d !== e || we_cnt !== we0) begin
      errors++;
      $display("FAIL rrq_wrq d=%h we=%0d (to=%0d) want %h %0d",
               d, we_cnt, to, e, we0);
    end
    mcu_read(24'h40, d, to);
    checks++;
    if (to || d !== e) begin
      errors++;
      $display("FAIL rrq_wrq_ram got %h want %h", d, e);
    end
  endtask

  task automatic run_pair(input bit do_s, input bit s_w, input bit s_e,
                          input logic [23:0] s_a, input logic [7:0] s_d,
                          input bit do_m, input bit m_r, input bit m_w,
                          input logic [23:0] m_a, input logic [7:0] m_d,
                          input int s_dly);
    logic [7:0] es, em;
    bit s_ok, m_ok, mfirst;
    int done_k;
    mfirst = do_m && do_s && (s_dly > 0);
    es = '0;
    em = '0;
    for (int o = 0; o < 2; o++) begin
      if (do_s && ((o == 0) != mfirst)) begin
        if (!s_w) es = ref_get(s_a);
        else if (s_e) refm[int'(s_a)] = s_d;
      end
      if (do_m && ((o == 0) == mfirst)) begin
        if (m_r) em = ref_get(m_a);
        else refm[int'(m_a)] = m_d;
      end
    end
    s_ok = !do_s;
    m_ok = !do_m;
    done_k = -1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (k > 0) begin
        if (snes_valid) begin
          checks++;
          if (s_ok || k <= s_dly || (!s_w && snes_dout !== es)) begin
            errors++;
            $display("FAIL rnd_snes k=%0d d=%h want %h", k, snes_dout, es);
          end
          s_ok = 1;
        end
        if (!m_ok && mcu_rdy) begin
          m_ok = 1;
          if (m_r) begin
            checks++;
            if (mcu_dout !== em) begin
              errors++;
              $display("FAIL rnd_mcu a=%h got %h want %h", m_a, mcu_dout, em);
            end
          end
        end
      end
      snes_req = do_s && (k == s_dly);
      snes_we = s_w;
      snes_wr_en = s_e;
      snes_addr = s_a;
      snes_din = s_d;
      mcu_rrq = do_m && (k == 0) && m_r;
      mcu_wrq = do_m && (k == 0) && m_w;
      mcu_addr = m_a;
      mcu_din = m_d;
      if (s_ok && m_ok && done_k < 0) done_k = k;
      if (done_k >= 0 && k >= done_k + 3) break;
    end
    snes_req = 0;
    mcu_rrq = 0;
    mcu_wrq = 0;
    if (!(s_ok && m_ok)) begin
      checks++;
      errors++;
      $display("FAIL rnd_timeout s=%0d m=%0d want 1 1", s_ok, m_ok);
    end
  endtask

  task automatic test_random;
    bit do_s, do_m, s_w, s_e, m_r, m_w;
    logic [23:0] s_a, m_a;
    int dly;
    for (int i = 0; i < 60; i++) begin
      do_s = 1'($urandom_range(0, 1));
      do_m = !do_s || ($urandom_range(0, 1) == 1);
      s_w = 1'($urandom_range(0, 1));
      s_e = ($urandom_range(0, 3) != 0);
      m_r = 1'($urandom_range(0, 1));
      m_w = !m_r || ($urandom_range(0, 3) == 0);
      s_a = {($urandom_range(0, 1) == 1) ? 8'hC0 : 8'h00, 11'h0,
             5'($urandom_range(0, 31))};
      m_a = {($urandom_range(0, 1) == 1) ? 8'hC0 : 8'h00, 11'h0,
             5'($urandom_range(0, 31))};
      dly = ($urandom_range(0, 1) == 1) ? 2 : 0;
      run_pair(do_s, s_w, s_e, s_a, 8'($urandom), do_m, m_r, m_w, m_a,
               8'($urandom), dly);
    end
    checks++;
    if (ov_viol !== 0) begin
      errors++;
      $display("FAIL oe_overlap got %0d want 0", ov_viol);
    end
    checks++;
    if (a_viol !== 0 || pin_viol !== 0) begin
      errors++;
      $display("FAIL addr_hold a=%0d pin=%0d want 0 0", a_viol, pin_viol);
    end
  endtask

  initial begin
    test_reset;
    test_snes_read;
    test_snes_write;
    test_arbitration;
    test_wr_disabled;
    test_rrq_wrq;
    test_reset_mid_write;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
